// File: rtl/instr_fetch_if.sv
// instr_fetch_if: redirect, imem request/response and decoder handshake bundle for instr_fetch
interface instr_fetch_if;
  logic        io_redirect_valid;
  logic [31:0] io_redirect_pc;
  logic        io_imem_req_valid;
  logic        io_imem_req_ready;
  logic [31:0] io_imem_req_addr;
  logic        io_imem_resp_valid;
  logic [31:0] io_imem_resp_data;
  logic        io_dec_valid;
  logic        io_dec_ready;
  logic [31:0] io_dec_instr;
  logic [31:0] io_dec_pc;
  modport master (
    input  io_redirect_valid, io_redirect_pc, io_imem_req_ready, io_imem_resp_valid,
           io_imem_resp_data, io_dec_ready,
    output io_imem_req_valid, io_imem_req_addr, io_dec_valid, io_dec_instr, io_dec_pc
  );
  modport slave (
    output io_redirect_valid, io_redirect_pc, io_imem_req_ready, io_imem_resp_valid,
           io_imem_resp_data, io_dec_ready,
    input  io_imem_req_valid, io_imem_req_addr, io_dec_valid, io_dec_instr, io_dec_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: PC sequencing, bounded outstanding imem requests with PC tags, decoder FIFO and redirect flush
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_2000,
  parameter int          DEPTH    = 2
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master io
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
  endfunction

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, cnt_q, cnt_d;
  logic [31:0]   tag_q [DEPTH], tag_d [DEPTH];
  logic [AW-1:0] tag_rp_q, tag_rp_d, tag_wp_q, tag_wp_d;
  logic [31:0]   bins_q [DEPTH], bins_d [DEPTH];
  logic [31:0]   bpc_q [DEPTH], bpc_d [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic          dec_valid, pop, req_valid, hs, resp, push;

  assign dec_valid = cnt_q != '0;
  assign pop       = dec_valid && io.io_dec_ready;
  // the slot freed by this cycle's pop is reusable so latency-1 memory sustains one instruction per cycle
  assign req_valid = !reset && !io.io_redirect_valid &&
                     (({1'b0, out_q} + {1'b0, cnt_q} - (CW+1)'(pop)) < (CW+1)'(DEPTH));
  assign hs        = req_valid && io.io_imem_req_ready;
  assign resp      = io.io_imem_resp_valid && out_q != '0;
  assign push      = resp && !io.io_redirect_valid && drop_q == '0;

  assign io.io_imem_req_valid = req_valid;
  assign io.io_imem_req_addr  = pc_q;
  assign io.io_dec_valid      = dec_valid;
  assign io.io_dec_instr      = dec_valid ? bins_q[head_q] : NOP;
  assign io.io_dec_pc         = dec_valid ? bpc_q[head_q] : '0;

  always_comb begin
    pc_d     = hs ? pc_q + 32'd4 : pc_q;
    out_d    = out_q + CW'(hs) - CW'(resp);
    drop_d   = (resp && drop_q != '0) ? drop_q - CW'(1) : drop_q;
    tag_d    = tag_q;
    tag_wp_d = hs ? inc(tag_wp_q) : tag_wp_q;
    tag_rp_d = resp ? inc(tag_rp_q) : tag_rp_q;
    bins_d   = bins_q;
    bpc_d    = bpc_q;
    head_d   = pop ? inc(head_q) : head_q;
    tail_d   = push ? inc(tail_q) : tail_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    if (hs) tag_d[tag_wp_q] = pc_q;
    if (push) begin
      bins_d[tail_q] = io.io_imem_resp_data;
      bpc_d[tail_q]  = tag_q[tag_rp_q];
    end
    // tags stay queued so the responses still in flight are matched and dropped in order
    if (io.io_redirect_valid) begin
      pc_d   = io.io_redirect_pc;
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
      drop_d = out_q - CW'(resp);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      cnt_q    <= '0;
      tag_q    <= '{default: '0};
      tag_rp_q <= '0;
      tag_wp_q <= '0;
      bins_q   <= '{default: '0};
      bpc_q    <= '{default: '0};
      head_q   <= '0;
      tail_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
      tag_q    <= tag_d;
      tag_rp_q <= tag_rp_d;
      tag_wp_q <= tag_wp_d;
      bins_q   <= bins_d;
      bpc_q    <= bpc_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and randomized checks of instr_fetch against a queue-based fetch model
module tb_instr_fetch;
  localparam int DEPTH = 2;
  logic clk = 0;
  logic reset = 0;
  instr_fetch_if bus();
  instr_fetch #(.RESET_PC(32'h0000_2000), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .io(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int edges = 0;
  always @(posedge clk) edges++;

  logic [31:0] m_pc;
  logic [31:0] m_inf[$];
  bit          m_stale[$];
  logic [31:0] m_buf_pc[$];
  logic [31:0] m_buf_ins[$];
  logic [31:0] mem_addr[$];
  int          mem_due[$];
  logic [31:0] salt = 0;
  int          max_lat = 1;
  bit          mem_go = 1;
  logic [31:0] seen_pc[$];
  logic [31:0] seen_ins[$];
  int          seen_cyc[$];
  int          req_count;
  bit          last_rv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] seen_at(input int i);
    return seen_pc.size() > i ? seen_pc[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0000_2000;
    m_inf.delete(); m_stale.delete(); m_buf_pc.delete(); m_buf_ins.delete();
    mem_addr.delete(); mem_due.delete();
    seen_pc.delete(); seen_ins.delete(); seen_cyc.delete();
    req_count = 0;
  endtask

  task automatic idle_inputs();
    bus.io_redirect_valid = 0; bus.io_redirect_pc = 0; bus.io_imem_req_ready = 0;
    bus.io_imem_resp_valid = 0; bus.io_imem_resp_data = 0; bus.io_dec_ready = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    #2;
    chk("rst_req_valid", 32'(bus.io_imem_req_valid), 0);
    chk("rst_dec_valid", 32'(bus.io_dec_valid), 0);
    chk("rst_dec_instr", bus.io_dec_instr, 32'h13);
    chk("rst_dec_pc", bus.io_dec_pc, 0);
    @(posedge clk); #1;
    reset = 0;
    model_reset();
  endtask

  task automatic step(input bit redir, input logic [31:0] tgt, input bit rdy, input bit dready);
    bit resp, pop, erv, edv, s;
    logic [31:0] a;
    int due;
    resp = mem_addr.size() > 0 && mem_due[0] <= cyc && mem_go;
    bus.io_redirect_valid  = redir;
    bus.io_redirect_pc     = tgt;
    bus.io_imem_req_ready  = rdy;
    bus.io_imem_resp_valid = resp;
    bus.io_imem_resp_data  = resp ? mem_addr[0] ^ salt : $urandom();
    bus.io_dec_ready       = dready;
    #2;
    edv = m_buf_pc.size() > 0;
    pop = edv && dready;
    erv = !redir && (m_inf.size() + m_buf_pc.size() - int'(pop) < DEPTH);
    chk("req_valid", 32'(bus.io_imem_req_valid), 32'(erv));
    chk("req_addr", bus.io_imem_req_addr, m_pc);
    chk("dec_valid", 32'(bus.io_dec_valid), 32'(edv));
    chk("dec_instr", bus.io_dec_instr, edv ? m_buf_ins[0] : 32'h13);
    chk("dec_pc", bus.io_dec_pc, edv ? m_buf_pc[0] : 32'h0);
    last_rv = bus.io_imem_req_valid;
    if (bus.io_dec_valid && dready) begin
      seen_pc.push_back(bus.io_dec_pc); seen_ins.push_back(bus.io_dec_instr); seen_cyc.push_back(cyc);
    end
    if (bus.io_imem_req_valid && rdy) req_count++;
    if (pop) begin void'(m_buf_pc.pop_front()); void'(m_buf_ins.pop_front()); end
    if (redir) begin m_buf_pc.delete(); m_buf_ins.delete(); end
    if (resp) begin
      a = m_inf.pop_front();
      s = m_stale.pop_front();
      void'(mem_addr.pop_front()); void'(mem_due.pop_front());
      if (!s && !redir) begin m_buf_pc.push_back(a); m_buf_ins.push_back(a ^ salt); end
    end
    if (redir) foreach (m_stale[i]) m_stale[i] = 1;
    if (erv && rdy) begin
      m_inf.push_back(m_pc); m_stale.push_back(0);
      due = cyc + 1 + int'($urandom_range(max_lat - 1, 0));
      if (mem_due.size() > 0 && mem_due[$] > due) due = mem_due[$];
      mem_addr.push_back(m_pc); mem_due.push_back(due);
      m_pc += 32'd4;
    end
    if (redir) m_pc = tgt;
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    int n, e0;
    idle_inputs();
    #1;
    do_reset();
    repeat (6) step(0, 0, 1, 1);
    chk("A_pc0", seen_at(0), 32'h2000);
    chk("A_pc1", seen_at(1), 32'h2004);
    chk("A_pc2", seen_at(2), 32'h2008);
    chk("A_consec", seen_cyc.size() > 2 ? 32'(seen_cyc[2] - seen_cyc[0]) : 0, 2);
    chk("A_instr_eq_pc", seen_ins.size() > 2 ? seen_ins[2] : 0, seen_at(2));

    do_reset();
    repeat (5) step(0, 0, 1, 0);
    chk("B_req_count", 32'(req_count), 2);
    chk("B_dec_pc_held", bus.io_dec_pc, 32'h2000);
    chk("B_dec_valid", 32'(bus.io_dec_valid), 1);
    chk("B_req_blocked", 32'(bus.io_imem_req_valid), 0);
    repeat (4) step(0, 0, 1, 1);

    do_reset();
    mem_go = 0;
    repeat (3) step(0, 0, 1, 1);
    step(1, 32'h8000, 1, 1);
    mem_go = 1;
    repeat (8) step(0, 0, 1, 1);
    chk("C_first_pc", seen_at(0), 32'h8000);
    n = 0;
    foreach (seen_pc[i]) if (seen_pc[i] >= 32'h2000 && seen_pc[i] <= 32'h200C) n++;
    chk("C_no_stale", 32'(n), 0);

    do_reset();
    repeat (3) step(0, 0, 1, 1);
    step(1, 32'h4000, 1, 1);
    chk("D_req_in_redirect", 32'(last_rv), 0);
    chk("D_buf_empty", 32'(bus.io_dec_valid), 0);
    repeat (5) step(0, 0, 1, 1);
    chk("D_seq1", seen_at(1), 32'h2004);
    chk("D_seq2", seen_at(2), 32'h4000);

    do_reset();
    repeat (2) step(0, 0, 1, 1);
    step(1, 32'hFFFF_FFFC, 1, 1);
    repeat (6) step(0, 0, 1, 1);
    chk("E_wrap_pc", seen_at(1), 32'hFFFF_FFFC);
    chk("E_wrapped", seen_at(2), 32'h0);

    do_reset();
    repeat (4) step(0, 0, 1, 1);
    chk("F_pre_dv", 32'(bus.io_dec_valid), 1);
    #2;
    e0 = edges;
    reset = 1;
    #1;
    chk("F_async_dv", 32'(bus.io_dec_valid), 0);
    chk("F_async_rv", 32'(bus.io_imem_req_valid), 0);
    chk("F_no_edge", 32'(edges - e0), 0);
    do_reset();
    repeat (4) step(0, 0, 1, 1);
    chk("F_restart", seen_at(0), 32'h2000);

    do_reset();
    salt = $urandom();
    max_lat = 3;
    repeat (600) begin
      mem_go = $urandom_range(0, 3) != 0;
      step($urandom_range(0, 19) == 0, $urandom() & 32'hFFFF_FFFC,
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
